scim_jtag_mem_bridge: RTL and testbench
=======================================

# scim_jtag_mem_bridge

Target-side responder for the JTAG memory-access protocol. It accepts decoded command words (write, read, start-compute, status) from the JTAG data-register capture logic, already resynchronised into the `clk` domain. It executes them against the activation-memory banks and returns read data and status back toward the TAP. It sits in SCIM_TOP between the JTAG controller and the activation memory/compute sequencer, and it owns the `done` flag the host polls.

## Interface
- `BANKS`, 4 — number of activation memory banks (ACT_MEM_BANKS).
- `ADDR_W`, 10 — word address width per bank.
- `DATA_W`, 32 — memory word width.
- `BANK_W`, 2 — bank-select field width (holds values up to 2^BANK_W−1 ≥ BANKS−1).

Ports:
- `clk`  in  1  — single clock. All logic is on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `cmd_valid`  in  1 / `cmd_ready`  out  1 — command handshake.
- `cmd_op`  in  2  — opcodes: 00 status, 01 write, 10 read, 11 start.
- `cmd_bank`  in  BANK_W; `cmd_addr`  in  ADDR_W; `cmd_wdata`  in  DATA_W.
- `rsp_valid`  out  1 / `rsp_ready`  in  1 — response handshake.
- `rsp_data`  out  DATA_W; `rsp_err`  out  1.
- `mem_en`  out  BANKS  — one-hot bank enable.
- `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  BANKS*DATA_W — bank b occupies bits [b*DATA_W +: DATA_W]. Read latency is 1 cycle.
- `start`  out  1  — single-cycle compute start pulse.
- `compute_done`  in  1  — single-cycle pulse from the sequencer.
- `done`  out  1  — sticky completion flag.

## Operation
- FSM states: IDLE, WR, RD_REQ, RD_WAIT, RSP, RUN.
- IDLE: `cmd_ready`=1. A command is accepted on `cmd_valid & cmd_ready`, and the op, bank, addr and wdata are registered.
- Error check at accept: `cmd_bank` ≥ BANKS on a write or read → no memory access; go to RSP with `rsp_err`=1 and `rsp_data`=0.
- Write: go to WR. For one cycle, `mem_en[bank]`=1, `mem_we`=1, addr and wdata are driven. Then return to IDLE, or go to RSP when SCIM_BRIDGE_WACK_EN is defined.
- Read: RD_REQ drives `mem_en[bank]`=1 and `mem_we`=0. RD_WAIT captures the selected bank slice of `mem_rdata` into the response register. Then go to RSP.
- Status: go straight to RSP. `rsp_data` = {DATA_W−2 zeros, busy, done}, where busy = (state==RUN).
- Start: pulse `start` for one cycle, clear `done`, and enter RUN. In RUN, `cmd_ready`=1:
  - A status command returns a status response without leaving RUN.
  - Write, read or start → error response (`rsp_err`=1), then return to RUN.
- `compute_done` in RUN: set `done`=1 and go to IDLE. A `compute_done` outside RUN is ignored.
- RSP: `rsp_valid`=1, held with stable data until `rsp_ready`. Then go to IDLE, or back to RUN if entered from RUN. `cmd_ready`=0 while in RSP.
- If `compute_done` arrives while in RSP entered from RUN, it is latched and applied when the response completes.

## Timing
- Reset values: state IDLE; `cmd_ready`=0 in the reset cycle and 1 from the following cycle; `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `start`=0, `done`=0.
- Reset mid-operation aborts any pending access or response. No memory strobe is issued in the reset cycle.
- Write: memory strobe occurs 1 cycle after accept. The next command can be accepted 2 cycles after the previous accept when WACK is off.
- Read: `mem_en` is asserted 1 cycle after accept. `rsp_valid` rises 3 cycles after accept.
- Status: `rsp_valid` rises 1 cycle after accept.
- `start` is high exactly 1 cycle, 1 cycle after the start command is accepted.
- Only one command is outstanding at a time. There is no command or response buffering.
- Memory outputs are registered. `mem_en` is 0 whenever no access is in progress.

## Configuration
- `SCIM_BRIDGE_WACK_EN` defined: every write produces a response beat (`rsp_data`=0, `rsp_err`=0). The host can count acknowledgements to confirm completion.
- Undefined: writes are silent. Only reads, status commands and errors produce responses. A write with an invalid bank still produces an error response.

## Test plan
- Reset, then write bank 2 addr 0x005 data 0xDEADBEEF → single `mem_en`=4'b0100 cycle with `mem_we`=1 and matching addr/data. A later read of bank 2 addr 0x005 (model returns 0xDEADBEEF) → `rsp_data`=0xDEADBEEF, `rsp_err`=0, `rsp_valid` 3 cycles after accept.
- Loop: write 10 words to each of the 4 banks, then read all back with `rsp_ready` toggling randomly → all 40 responses match and stay stable while stalled.
- Read bank 5 with BANKS=4, BANK_W=3 → no `mem_en` pulse; response `rsp_err`=1, `rsp_data`=0.
- Start → `start` pulses once and `done`=0. Status → `rsp_data`=0x2. Write during RUN → `rsp_err`=1 with no memory strobe. `compute_done` pulse → `done`=1, and status → 0x1.
- `compute_done` asserted while a RUN-status response is stalled (`rsp_ready`=0 for 5 cycles) → `done`=1 and state IDLE after the handshake.
- Reset asserted in RD_WAIT → no response. All outputs return to their reset values the next cycle. A fresh read completes normally.
- Build with and without SCIM_BRIDGE_WACK_EN → write acknowledgements present or absent, respectively.

Source files
------------

// File: rtl/scim_jtag_mem_bridge.sv
// rtl/scim_jtag_mem_bridge.sv - JTAG command responder for activation memory banks; SCIM_BRIDGE_WACK_EN adds write acknowledgements
// Single-outstanding command engine: memory write/read, status poll, compute start and sticky done flag.
module scim_jtag_mem_bridge #(
    parameter int BANKS  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BANK_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [BANK_W-1:0]       cmd_bank,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [DATA_W-1:0]       cmd_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_err,
    output logic [BANKS-1:0]        mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [BANKS*DATA_W-1:0] mem_rdata,
    output logic                    start,
    input  logic                    compute_done,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RSP, RUN} state_t;

    localparam logic [1:0] OP_STATUS = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_START  = 2'b11;

    state_t              state_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [BANKS-1:0]    mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                start_q;
    logic                done_q;
    logic [BANK_W-1:0]   bank_q;
    logic                from_run_q;
    logic                done_pend_q;

    logic                bank_ok;
    logic [BANKS-1:0]    bank_oh;
    logic [DATA_W-1:0]   rd_word;
    logic                accept;

    always_comb begin
        bank_ok = (int'(cmd_bank) < BANKS);
        bank_oh = '0;
        rd_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (int'(cmd_bank) == b) bank_oh[b] = 1'b1;
            if (int'(bank_q) == b) rd_word = mem_rdata[b*DATA_W +: DATA_W];
        end
    end

    assign accept = cmd_valid && cmd_ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            bank_q      <= '0;
            from_run_q  <= 1'b0;
            done_pend_q <= 1'b0;
        end else begin
            // Strobes default low so every access and start pulse lasts exactly one cycle
            start_q  <= 1'b0;
            mem_en_q <= '0;
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        from_run_q  <= 1'b0;
                        done_pend_q <= 1'b0;
                        bank_q      <= cmd_bank;
                        case (cmd_op)
                            OP_STATUS: begin
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_data_q  <= DATA_W'({1'b0, done_q});
                                state_q     <= RSP;
                            end
                            OP_WRITE, OP_READ: begin
                                if (bank_ok) begin
                                    mem_en_q    <= bank_oh;
                                    mem_we_q    <= (cmd_op == OP_WRITE);
                                    mem_addr_q  <= cmd_addr;
                                    mem_wdata_q <= cmd_wdata;
                                    state_q     <= (cmd_op == OP_WRITE) ? WR : RD_REQ;
                                end else begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_err_q   <= 1'b1;
                                    rsp_data_q  <= '0;
                                    state_q     <= RSP;
                                end
                            end
                            default: begin
                                start_q     <= 1'b1;
                                done_q      <= 1'b0;
                                cmd_ready_q <= 1'b1;
                                state_q     <= RUN;
                            end
                        endcase
                    end
                end
                WR: begin
`ifdef SCIM_BRIDGE_WACK_EN
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                    state_q     <= RSP;
`else
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
`endif
                end
                RD_REQ: begin
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= rd_word;
                    state_q     <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        done_pend_q <= 1'b0;
                        // A completion seen while the RUN response was stalled finishes the run here
                        if (from_run_q && !(done_pend_q || compute_done)) begin
                            state_q <= RUN;
                        end else begin
                            if (from_run_q) done_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else if (from_run_q && compute_done) begin
                        done_pend_q <= 1'b1;
                    end
                end
                RUN: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        from_run_q  <= 1'b1;
                        done_pend_q <= compute_done;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= (cmd_op != OP_STATUS);
                        rsp_data_q  <= (cmd_op == OP_STATUS) ? DATA_W'({1'b1, done_q}) : '0;
                        state_q     <= RSP;
                    end else if (compute_done) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cmd_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign start     = start_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scim_jtag_mem_bridge.sv
// tb/tb_scim_jtag_mem_bridge.sv - directed/randomized bench for scim_jtag_mem_bridge
// Reference memory contents are tracked per (bank,addr) key; a simple 1-cycle memory answers reads.
module tb_scim_jtag_mem_bridge;

    localparam int BANKS  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BANK_W = 3;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [1:0]              cmd_op = '0;
    logic [BANK_W-1:0]       cmd_bank = '0;
    logic [ADDR_W-1:0]       cmd_addr = '0;
    logic [DATA_W-1:0]       cmd_wdata = '0;
    logic                    rsp_valid;
    logic                    rsp_ready = 1'b0;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic [BANKS-1:0]        mem_en;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic [BANKS*DATA_W-1:0] mem_rdata = '0;
    logic                    start;
    logic                    compute_done = 1'b0;
    logic                    done;

    scim_jtag_mem_bridge #(
        .BANKS(BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BANK_W(BANK_W)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .start(start), .compute_done(compute_done), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DATA_W-1:0] mem_arr [BANKS][1024];
    always @(posedge clk) begin
        for (int b = 0; b < BANKS; b++) begin
            if (mem_en[b]) begin
                if (mem_we) mem_arr[b][mem_addr] <= mem_wdata;
                else        mem_rdata[b*DATA_W +: DATA_W] <= mem_arr[b][mem_addr];
            end
        end
    end

    int               strobes = 0;
    int               strobe_cyc = 0;
    int               start_cnt = 0;
    logic [BANKS-1:0] s_en = '0;
    logic             s_we = 1'b0;
    logic [ADDR_W-1:0] s_addr = '0;
    logic [DATA_W-1:0] s_data = '0;
    always @(negedge clk) begin
        if (mem_en !== '0) begin
            strobes++;
            strobe_cyc = cyc;
            s_en   = mem_en;
            s_we   = mem_we;
            s_addr = mem_addr;
            s_data = mem_wdata;
        end
        if (start === 1'b1) start_cnt++;
    end

    int tests = 0;
    int failed = 0;
    bit rand_ready = 1'b0;
    logic [DATA_W-1:0] ref_mem [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [BANK_W-1:0] b,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int acc);
        cmd_op = op; cmd_bank = b; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("cmd_accept", 64'(acc >= 0), 64'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [DATA_W-1:0] d, output logic e, output int first);
        logic [DATA_W-1:0] d0 = '0;
        logic e0 = 1'b0;
        bit seen = 1'b0;
        bit hs = 1'b0;
        first = -1;
        for (int i = 0; i < 200 && !hs; i++) begin
            if (rsp_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1; first = cyc; d0 = rsp_data; e0 = rsp_err;
                end else begin
                    check("rsp_stable_data", 64'(rsp_data), 64'(d0));
                    check("rsp_stable_err", 64'(rsp_err), 64'(e0));
                end
                rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rsp_ready) hs = 1'b1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        d = d0; e = e0;
        check("rsp_handshake", 64'(hs), 64'(1));
    endtask

    task automatic do_write(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        int acc, f;
        logic [DATA_W-1:0] rd;
        logic re;
        send(2'b01, b, a, d, acc);
        ref_mem[int'(b)*1024 + int'(a)] = d;
        @(negedge clk);
`ifdef SCIM_BRIDGE_WACK_EN
        get_rsp(rd, re, f);
        check("wack_data", 64'(rd), 64'(0));
        check("wack_err", 64'(re), 64'(0));
`else
        rd = '0; re = 1'b0; f = 0;
        check("no_wack", 64'(rsp_valid), 64'(0));
`endif
    endtask

    task automatic do_read(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] exp_d, input logic exp_e, input int exp_lat);
        int acc, f;
        logic [DATA_W-1:0] rd;
        logic re;
        send(2'b10, b, a, '0, acc);
        get_rsp(rd, re, f);
        check("read_data", 64'(rd), 64'(exp_d));
        check("read_err", 64'(re), 64'(exp_e));
        if (!rand_ready) check("read_latency", 64'(f - acc), 64'(exp_lat));
    endtask

    task automatic do_status(input logic [DATA_W-1:0] exp_d);
        int acc, f;
        logic [DATA_W-1:0] rd;
        logic re;
        send(2'b00, '0, '0, '0, acc);
        get_rsp(rd, re, f);
        check("status_data", 64'(rd), 64'(exp_d));
        check("status_err", 64'(re), 64'(0));
        check("status_latency", 64'(f - acc), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
        check({tag, "_mem_en"}, 64'(mem_en), 64'(0));
        check({tag, "_mem_we"}, 64'(mem_we), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({tag, "_start"}, 64'(start), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, s0, c0, f, key;
        logic [DATA_W-1:0] rd, d;
        logic re;
        logic [BANK_W-1:0] b;
        logic [ADDR_W-1:0] a;
        int keys[$];
        bit saw_rsp;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Directed write then read of bank 2 addr 5
        s0 = strobes;
        send(2'b01, 3'd2, 10'h005, 32'hDEADBEEF, acc);
        ref_mem[2*1024 + 5] = 32'hDEADBEEF;
        #1;
        check("wr_strobe_count", 64'(strobes - s0), 64'(1));
        check("wr_strobe_en", 64'(s_en), 64'(4'b0100));
        check("wr_strobe_we", 64'(s_we), 64'(1));
        check("wr_strobe_addr", 64'(s_addr), 64'(10'h005));
        check("wr_strobe_data", 64'(s_data), 64'(32'hDEADBEEF));
        check("wr_strobe_cycle", 64'(strobe_cyc - acc), 64'(1));
`ifdef SCIM_BRIDGE_WACK_EN
        get_rsp(rd, re, f);
        check("wack_first_data", 64'(rd), 64'(0));
        check("wack_first_err", 64'(re), 64'(0));
        check("wack_first_latency", 64'(f - acc), 64'(2));
`else
        d = $urandom;
        send(2'b01, 3'd0, 10'h006, d, acc2);
        ref_mem[6] = d;
        check("wr_back_to_back_gap", 64'(acc2 - acc), 64'(2));
        @(negedge clk);
        check("wr_no_response", 64'(rsp_valid), 64'(0));
`endif
        do_read(3'd2, 10'h005, 32'hDEADBEEF, 1'b0, 3);

        // Randomized fill of every bank, read back with random backpressure
        s0 = strobes;
        for (int bk = 0; bk < BANKS; bk++) begin
            for (int i = 0; i < 10; i++) begin
                b = BANK_W'(bk);
                a = ADDR_W'($urandom_range(0, 1023));
                do_write(b, a, $urandom);
                keys.push_back(bk*1024 + int'(a));
            end
        end
        #1;
        check("fill_strobe_count", 64'(strobes - s0), 64'(40));
        rand_ready = 1'b1;
        foreach (keys[i]) begin
            key = keys[i];
            do_read(BANK_W'(key / 1024), ADDR_W'(key % 1024), ref_mem[key], 1'b0, 3);
        end
        rand_ready = 1'b0;

        // Out-of-range banks never touch memory and always answer with an error
        s0 = strobes;
        do_read(3'd5, 10'h010, 32'h0, 1'b1, 1);
        send(2'b01, 3'd6, 10'h011, 32'h12345678, acc);
        get_rsp(rd, re, f);
        check("bad_wr_err", 64'(re), 64'(1));
        check("bad_wr_data", 64'(rd), 64'(0));
        #1;
        check("bad_bank_no_strobe", 64'(strobes - s0), 64'(0));

        // Compute run: start pulse, busy status, rejected write, completion
        c0 = start_cnt;
        send(2'b11, '0, '0, '0, acc);
        #1;
        check("start_pulse", 64'(start_cnt - c0), 64'(1));
        check("done_cleared", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        #1;
        check("start_single", 64'(start_cnt - c0), 64'(1));
        do_status(32'h2);
        s0 = strobes;
        send(2'b01, 3'd1, 10'h020, 32'hCAFE0001, acc);
        get_rsp(rd, re, f);
        check("run_wr_err", 64'(re), 64'(1));
        check("run_wr_data", 64'(rd), 64'(0));
        #1;
        check("run_wr_no_strobe", 64'(strobes - s0), 64'(0));
        @(negedge clk);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        check("done_set", 64'(done), 64'(1));
        do_status(32'h1);
        compute_done = 1'b1;
        @(negedge clk);
        compute_done = 1'b0;
        do_status(32'h1);

        // Completion arriving while a RUN status response is stalled
        send(2'b11, '0, '0, '0, acc);
        send(2'b00, '0, '0, '0, acc);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(rsp_valid), 64'(1));
            check("stall_data", 64'(rsp_data), 64'(32'h2));
            check("stall_cmd_ready", 64'(cmd_ready), 64'(0));
            compute_done = (i == 1);
            @(negedge clk);
        end
        compute_done = 1'b0;
        check("done_held_off", 64'(done), 64'(0));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("done_after_hs", 64'(done), 64'(1));
        do_status(32'h1);

        // Reset while the read sits in RD_WAIT
        send(2'b10, 3'd2, 10'h005, '0, acc);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) saw_rsp = 1'b1;
        end
        check("no_rsp_after_reset", 64'(saw_rsp), 64'(0));
        do_read(3'd2, 10'h005, ref_mem[2*1024 + 5], 1'b0, 3);
        do_status(32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
